id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly downstream of the register file.
- Captures the decoded instruction with its two source operands (A, B) read combinationally from the register file, and presents them to the execute stage.
- Provides valid/ready flow control, flush, WB→ID bypass, and a refresh path for stale operands while the stage is held.
- Register-file write is posedge with combinational read, so a same-cycle write/read returns the old value. This block corrects that case.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/operand_fwd.sv | 25 ++
 rtl/id_ex_stage.sv | 108 ++++++++++
 tb/tb_id_ex_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core types and widths.
// Imported by decode, ID/EX and execute.
package cpu_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN = 32;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;
  localparam int CTRL_BUS_W = 16;

  typedef logic [CTRL_BUS_W-1:0] ctrl_t;
endpackage

// File: rtl/operand_fwd.sv
// Source operand select with WB->ID bypass.
// hit also drives the hold-refresh enable.
module operand_fwd
  import cpu_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs_num,
  input  logic [XLEN-1:0]      rf,
  input  logic [REG_IDX_W-1:0] wb_num,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 reg_write,
  output logic                 hit,
  output logic [XLEN-1:0]      opnd
);
  always_comb begin
    hit = reg_write
       && (wb_num == rs_num)
       && (rs_num != ZERO_REG);
    opnd = rf;
    unique case (1'b1)
      (rs_num == ZERO_REG): opnd = '0;
      hit:                  opnd = wb_data;
      default:              opnd = rf;
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bypass,
// hold-time operand refresh and stall counter.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [4:0]        R1Num,
  input  logic [4:0]        R2Num,
  input  logic [4:0]        DstNum,
  input  logic [31:0]       Imm,
  input  logic [31:0]       Pc,
  input  logic [CTRL_W-1:0] Ctrl,
  input  logic [31:0]       A,
  input  logic [31:0]       B,
  input  logic [31:0]       WbData,
  input  logic [4:0]        WbRegNum,
  input  logic              RegWrite,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [31:0]       ExA,
  output logic [31:0]       ExB,
  output logic [31:0]       ExImm,
  output logic [31:0]       ExPc,
  output logic [CTRL_W-1:0] ExCtrl,
  output logic [4:0]        ExR1Num,
  output logic [4:0]        ExR2Num,
  output logic [4:0]        ExDst,
  output logic [CNT_W-1:0]  StallCnt
);
  logic hold;
  logic load;
  logic hit1, hit2;
  logic [4:0] s1_num, s2_num;
  logic [31:0] op1, op2;

  assign InReady = !OutValid || OutReady;
  assign hold = OutValid && !OutReady;
  assign load = InValid && InReady && !Flush;

  // While held, compare against the captured indices
  assign s1_num = hold ? ExR1Num : R1Num;
  assign s2_num = hold ? ExR2Num : R2Num;

  operand_fwd u_fwd1 (
    .rs_num   (s1_num),
    .rf       (A),
    .wb_num   (WbRegNum),
    .wb_data  (WbData),
    .reg_write(RegWrite),
    .hit      (hit1),
    .opnd     (op1)
  );

  operand_fwd u_fwd2 (
    .rs_num   (s2_num),
    .rf       (B),
    .wb_num   (WbRegNum),
    .wb_data  (WbData),
    .reg_write(RegWrite),
    .hit      (hit2),
    .opnd     (op2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      OutValid <= 1'b0;
      ExA      <= '0;
      ExB      <= '0;
      ExImm    <= '0;
      ExPc     <= '0;
      ExCtrl   <= '0;
      ExR1Num  <= '0;
      ExR2Num  <= '0;
      ExDst    <= '0;
    end else if (Flush) begin
      OutValid <= 1'b0;
    end else if (load) begin
      OutValid <= 1'b1;
      ExA      <= op1;
      ExB      <= op2;
      ExImm    <= Imm;
      ExPc     <= Pc;
      ExCtrl   <= Ctrl;
      ExR1Num  <= R1Num;
      ExR2Num  <= R2Num;
      ExDst    <= DstNum;
    end else if (hold) begin
      if (hit1) ExA <= WbData;
      if (hit2) ExB <= WbData;
    end else begin
      OutValid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      StallCnt <= '0;
    else if (hold && (StallCnt != '1))
      StallCnt <= StallCnt + 1'b1;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Scenario bench for id_ex_stage.
// Expected operands queued at drive time.
module tb_id_ex_stage;
  localparam int CW = 16;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst;
  logic InValid, InReady;
  logic [4:0] R1Num, R2Num, DstNum;
  logic [31:0] Imm, Pc, A, B, WbData;
  logic [CW-1:0] Ctrl;
  logic [4:0] WbRegNum;
  logic RegWrite, Flush;
  logic OutValid, OutReady;
  logic [31:0] ExA, ExB, ExImm, ExPc;
  logic [CW-1:0] ExCtrl;
  logic [4:0] ExR1Num, ExR2Num, ExDst;
  logic [NW-1:0] StallCnt;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst),
    .InValid(InValid), .InReady(InReady),
    .R1Num(R1Num), .R2Num(R2Num),
    .DstNum(DstNum), .Imm(Imm), .Pc(Pc),
    .Ctrl(Ctrl), .A(A), .B(B),
    .WbData(WbData), .WbRegNum(WbRegNum),
    .RegWrite(RegWrite), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady),
    .ExA(ExA), .ExB(ExB),
    .ExImm(ExImm), .ExPc(ExPc),
    .ExCtrl(ExCtrl),
    .ExR1Num(ExR1Num), .ExR2Num(ExR2Num),
    .ExDst(ExDst), .StallCnt(StallCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; InValid = 0; Flush = 0;
    OutReady = 1; RegWrite = 0;
    WbRegNum = 0; WbData = 0;
    R1Num = 0; R2Num = 0; DstNum = 0;
    Imm = 0; Pc = 0; Ctrl = 0;
    A = 0; B = 0;
  endtask

  task automatic drv(input logic [4:0] r1,
                     input logic [4:0] r2,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] pc);
    InValid = 1; R1Num = r1; R2Num = r2;
    A = a; B = b; Pc = pc;
    Imm = pc ^ 32'h5a5a; DstNum = r1 + 5'd1;
    Ctrl = pc[15:0];
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (OutValid !== 1'b0 || ExA !== 0 || ExPc !== 0
        || StallCnt !== 0 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_state v=%b a=%h pc=%h cnt=%0d rdy=%b",
               OutValid, ExA, ExPc, StallCnt, InReady);
    end
    OutReady = 0;
    drv(5'd3, 5'd4, 32'h33, 32'h44, 32'h100);
    tick();
    checks++;
    if (OutValid !== 1'b1 || ExA !== 32'h33) begin
      errors++;
      $display("FAIL reset_preload v=%b a=%h exp 1 33", OutValid, ExA);
    end
    rst = 1;
    tick();
    checks++;
    if (OutValid !== 1'b0 || ExA !== 0 || StallCnt !== 0) begin
      errors++;
      $display("FAIL reset_mid v=%b a=%h cnt=%0d exp 0 0 0",
               OutValid, ExA, StallCnt);
    end
    idle();
  endtask

  task automatic test_bypass();
    do_reset();
    drv(5'd5, 5'd6, 32'h11, 32'h22, 32'h200);
    RegWrite = 1; WbRegNum = 5; WbData = 32'hABCD;
    q.push_back('{a: 32'hABCD, b: 32'h22, pc: 32'h200});
    tick();
    e = q.pop_front();
    checks++;
    if (OutValid !== 1'b1 || ExA !== e.a || ExB !== e.b) begin
      errors++;
      $display("FAIL bypass v=%b a=%h b=%h exp a=%h b=%h",
               OutValid, ExA, ExB, e.a, e.b);
    end
    checks++;
    if (ExPc !== e.pc || ExImm !== (e.pc ^ 32'h5a5a)
        || ExDst !== 5'd6 || ExCtrl !== e.pc[15:0]
        || ExR1Num !== 5'd5 || ExR2Num !== 5'd6) begin
      errors++;
      $display("FAIL bypass_fields pc=%h imm=%h dst=%0d exp pc=%h",
               ExPc, ExImm, ExDst, e.pc);
    end
    idle();
    tick();
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL bypass_drain v=%b exp 0", OutValid);
    end
  endtask

  task automatic test_r0();
    do_reset();
    OutReady = 0;
    drv(5'd0, 5'd3, 32'hFFFF, 32'h33, 32'h300);
    RegWrite = 1; WbRegNum = 0; WbData = 32'h1234;
    tick();
    checks++;
    if (ExA !== 0 || ExB !== 32'h33) begin
      errors++;
      $display("FAIL r0_load a=%h b=%h exp 0 33", ExA, ExB);
    end
    InValid = 0;
    tick();
    checks++;
    if (ExA !== 0 || ExB !== 32'h33 || OutValid !== 1'b1) begin
      errors++;
      $display("FAIL r0_hold a=%h b=%h v=%b exp 0 33 1",
               ExA, ExB, OutValid);
    end
    idle();
  endtask

  task automatic test_hold_refresh();
    do_reset();
    OutReady = 0;
    drv(5'd1, 5'd7, 32'h5, 32'h10, 32'h400);
    tick();
    checks++;
    if (ExB !== 32'h10 || InReady !== 1'b0 || StallCnt !== 0) begin
      errors++;
      $display("FAIL hold_load b=%h rdy=%b cnt=%0d exp 10 0 0",
               ExB, InReady, StallCnt);
    end
    drv(5'd2, 5'd2, 32'hDEAD, 32'hBEEF, 32'h444);
    tick();
    RegWrite = 1; WbRegNum = 7; WbData = 32'h99;
    tick();
    RegWrite = 0;
    tick();
    checks++;
    if (ExB !== 32'h99 || ExA !== 32'h5 || ExPc !== 32'h400
        || StallCnt !== 3) begin
      errors++;
      $display("FAIL hold_refresh b=%h a=%h pc=%h cnt=%0d exp 99 5 400 3",
               ExB, ExA, ExPc, StallCnt);
    end
    checks++;
    if (InReady !== 1'b0) begin
      errors++;
      $display("FAIL hold_inready rdy=%b exp 0", InReady);
    end
    InValid = 0; OutReady = 1;
    tick();
    checks++;
    if (OutValid !== 1'b0 || StallCnt !== 3) begin
      errors++;
      $display("FAIL hold_drain v=%b cnt=%0d exp 0 3",
               OutValid, StallCnt);
    end
    OutReady = 0;
    drv(5'd8, 5'd8, 32'h1, 32'h2, 32'h500);
    tick();
    InValid = 0;
    RegWrite = 1; WbRegNum = 8; WbData = 32'h77;
    tick();
    checks++;
    if (ExA !== 32'h77 || ExB !== 32'h77) begin
      errors++;
      $display("FAIL hold_both a=%h b=%h exp 77 77", ExA, ExB);
    end
    RegWrite = 0;
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (StallCnt !== 4'hF) begin
      errors++;
      $display("FAIL stall_sat cnt=%0d exp 15", StallCnt);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(5'(i + 1), 5'(i + 10), 32'h1000 + i,
          32'h2000 + i, 32'h600 + 4 * i);
      q.push_back('{a: 32'h1000 + i, b: 32'h2000 + i,
                    pc: 32'h600 + 4 * i});
      tick();
      e = q.pop_front();
      checks++;
      if (OutValid !== 1'b1 || ExA !== e.a || ExB !== e.b
          || ExPc !== e.pc) begin
        errors++;
        $display("FAIL b2b_%0d v=%b a=%h b=%h pc=%h exp %h %h %h",
                 i, OutValid, ExA, ExB, ExPc, e.a, e.b, e.pc);
      end
    end
    InValid = 0;
    tick();
    checks++;
    if (OutValid !== 1'b0 || StallCnt !== 0) begin
      errors++;
      $display("FAIL b2b_end v=%b cnt=%0d exp 0 0", OutValid, StallCnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    OutReady = 0;
    drv(5'd1, 5'd2, 32'h111, 32'h112, 32'h700);
    q.push_back('{a: 32'h111, b: 32'h112, pc: 32'h700});
    tick();
    drv(5'd1, 5'd2, 32'h222, 32'h223, 32'h704);
    Flush = 1;
    tick();
    e = q.pop_front();
    checks++;
    if (OutValid !== 1'b0 || ExA === 32'h222 || ExPc !== e.pc
        || StallCnt !== 1) begin
      errors++;
      $display("FAIL flush v=%b a=%h pc=%h cnt=%0d exp 0 !222 %h 1",
               OutValid, ExA, ExPc, StallCnt, e.pc);
    end
    Flush = 0;
    drv(5'd1, 5'd2, 32'h333, 32'h334, 32'h708);
    tick();
    checks++;
    if (OutValid !== 1'b1 || ExA !== 32'h333 || ExPc !== 32'h708) begin
      errors++;
      $display("FAIL flush_reload v=%b a=%h pc=%h exp 1 333 708",
               OutValid, ExA, ExPc);
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_r0();
    test_hold_refresh();
    test_back_to_back();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
